inst_prefetch_buffer: RTL and testbench
=======================================

Name: inst_prefetch_buffer

Overview:
Instruction prefetch unit between the instruction memory port and the IF stage. It runs ahead of the pipeline, issuing word fetches over a req/ack handshake. Fetched {pc, inst} pairs are queued in a small FIFO that feeds stage_if. Branch redirects (br_ctrl/br_dst from EX) flush the queue, and any in-flight fetch is dropped cleanly. The pipeline stall holds the head entry.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INST, 32'h0000_0013, value driven on if_inst when the buffer is empty (addi x0,x0,0)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  pipeline stall; holds head entry, no pop
br_ctrl  input  1  redirect request, single-cycle pulse from EX
br_dst  input  32  redirect target; bits [1:0] forced to 0 internally
imem_req  output  1  fetch request, level
imem_addr  output  32  fetch word address; stable while imem_req=1 and no ack
imem_ack  input  1  fetch complete; imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction
if_valid  output  1  head entry valid (FIFO not empty)
if_pc  output  32  head pc when valid, else current fetch_pc
if_inst  output  32  head instruction when valid, else NOP_INST
count  output  $clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Reset (async, active-high):
  - FIFO emptied; rd/wr pointers = 0; count = 0.
  - fetch_pc = RESET_PC; state = IDLE.
  - Outputs: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=RESET_PC, if_inst=NOP_INST.
- Reset mid-transaction: an outstanding fetch is abandoned. Memory must tolerate the req drop.
- At most one fetch is outstanding. imem_addr = fetch_pc.
- FSM states: IDLE, REQ, DROP.
  - IDLE: imem_req=0. Go to REQ when count < DEPTH and br_ctrl=0. If br_ctrl=1, load fetch_pc and stay IDLE one cycle.
  - REQ: imem_req=1. On imem_ack with br_ctrl=0:
    - push {fetch_pc, imem_rdata};
    - fetch_pc += 4;
    - stay REQ if (count after this cycle's push/pop) < DEPTH, else go IDLE.
    - Back-to-back fetches carry no bubble.
  - REQ with br_ctrl=1:
    - With ack the same cycle: data discarded; fetch_pc=br_dst; stay REQ with the new address.
    - Without ack: go DROP; imem_addr keeps the old address.
  - DROP: imem_req=1, old address held. On imem_ack, discard the data and go REQ with fetch_pc=br_dst. A further br_ctrl in DROP only updates the pending target.
- Pop: head is removed when if_valid=1, stall=0 and br_ctrl=0.
  - Push and pop in the same cycle leave count unchanged.
  - Pop when empty is ignored.
- Flush: br_ctrl=1 empties the FIFO at the next edge. The flush has priority over any simultaneous push or pop. count=0 and if_valid=0 in the following cycle.
- Full: no new request is issued while count == DEPTH. A pop in the same cycle does not enable a request that cycle; the request starts next cycle. Overflow is impossible by construction.
- Latency: first instruction appears (if_valid=1) the cycle after the first ack. From reset release with zero-wait memory, that is cycle 2.
- Pointers wrap modulo DEPTH. count is a separate counter.
- fetch_pc wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
- stall does not block fetching. The buffer keeps filling until full.

Test Plan:
- Reset, zero-wait memory returning inst = addr|1 → fetch addresses 0x0, 0x4, 0x8… back-to-back. if_valid=1 from cycle 2 with if_pc=0x0, if_inst=0x1. One pop per cycle once no stall.
- stall held high for 10 cycles → count reaches 4; imem_req=0 while full. Head stays at pc 0x0. On release, pops resume in order 0x0, 0x4, 0x8, 0xC, and fetch restarts at 0x10.
- Memory with 3-cycle ack latency; br_ctrl pulse with br_dst=0x103 one cycle after req for 0x8 → imem_addr stays 0x8 until ack, and that data is dropped. Next request is to 0x100. if_valid=0 until 0x100 returns.
- br_ctrl coincident with imem_ack and a pop → FIFO empty next cycle; acked data not pushed; next imem_addr = br_dst.
- Assert reset while imem_req=1 and FIFO holds 3 entries → immediate if_valid=0, count=0, imem_req=0. After release, the first fetch is to RESET_PC.
- Run sequential fetch from 0xFFFF_FFF8 → pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 delivered in order.

Source files
------------

// File: rtl/inst_prefetch_buffer.sv
// inst_prefetch_buffer: runs ahead of IF, fetching words into a small {pc, inst} FIFO.
// Ports:
//   clk, reset          - clock; asynchronous active-high reset
//   stall               - hold head entry (no pop)
//   br_ctrl, br_dst     - redirect pulse and target (low two bits ignored)
//   imem_req/addr       - fetch request level and word address
//   imem_ack/rdata      - fetch completion and returned instruction
//   if_valid/pc/inst    - head entry toward IF (NOP and fetch_pc when empty)
//   count               - occupied entries
module inst_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     br_ctrl,
    input  logic [31:0]              br_dst,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    output logic                     if_valid,
    output logic [31:0]              if_pc,
    output logic [31:0]              if_inst,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        state, state_nx;
    logic [31:0]   fetch_pc, fetch_pc_nx, pend_pc, pend_pc_nx, dst;
    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   inst_q [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count_nx;
    logic          push, pop;

    assign dst       = {br_dst[31:2], 2'b00};
    assign if_valid  = count != '0;
    assign pop       = if_valid && !stall && !br_ctrl;
    assign push      = state == REQ && imem_ack && !br_ctrl;
    // A redirect flushes the queue and overrides any push/pop this cycle.
    assign count_nx  = br_ctrl ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
    assign imem_req  = state != IDLE;
    assign imem_addr = fetch_pc;
    assign if_pc     = if_valid ? pc_q[rd_ptr] : fetch_pc;
    assign if_inst   = if_valid ? inst_q[rd_ptr] : NOP_INST;

    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        pend_pc_nx  = pend_pc;
        case (state)
            IDLE: begin
                // Full check uses the current count, so a same-cycle pop
                // only enables the request on the following cycle.
                if (br_ctrl) fetch_pc_nx = dst;
                else if (count != FULL) state_nx = REQ;
            end
            REQ: begin
                if (br_ctrl && imem_ack) fetch_pc_nx = dst;
                else if (br_ctrl) begin
                    // Address must stay stable until the stale fetch completes.
                    state_nx   = DROP;
                    pend_pc_nx = dst;
                end else if (imem_ack) begin
                    fetch_pc_nx = fetch_pc + 32'd4;
                    state_nx    = count_nx == FULL ? IDLE : REQ;
                end
            end
            DROP: begin
                if (br_ctrl) pend_pc_nx = dst;
                if (imem_ack) begin
                    fetch_pc_nx = br_ctrl ? dst : pend_pc;
                    state_nx    = REQ;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            pend_pc  <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
            pend_pc  <= pend_pc_nx;
            rd_ptr   <= br_ctrl ? '0 : rd_ptr + AW'(pop);
            wr_ptr   <= br_ctrl ? '0 : wr_ptr + AW'(push);
            count    <= count_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]   <= fetch_pc;
            inst_q[wr_ptr] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// tb_inst_prefetch_buffer: directed bench for inst_prefetch_buffer with a latency-configurable memory.
// Ports: none (top-level bench).
module tb_inst_prefetch_buffer;
    logic        clk = 1'b0, reset = 1'b1, stall = 1'b1, br_ctrl = 1'b0;
    logic [31:0] br_dst = 32'h0;
    logic        imem_req, imem_ack, if_valid;
    logic [31:0] imem_addr, imem_rdata, if_pc, if_inst;
    logic [2:0]  count;
    int          checks = 0, failures = 0, lat = 0, wcnt = 0;

    inst_prefetch_buffer dut (
        .clk(clk), .reset(reset), .stall(stall), .br_ctrl(br_ctrl), .br_dst(br_dst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .count(count)
    );

    always #5 clk = ~clk;

    // Memory: acks once req has been held for lat cycles; returns addr|1.
    always @(posedge clk or posedge reset)
        if (reset) wcnt <= 0;
        else wcnt <= (imem_req && !imem_ack) ? wcnt + 1 : 0;
    assign imem_ack   = imem_req && wcnt >= lat;
    assign imem_rdata = imem_addr | 32'h1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset values
        cyc(1);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_inst", if_inst, 32'h13);
        check("rst_count", 32'(count), 32'd0);
        reset = 1'b0;
        // Zero-wait fill under stall, then drain
        cyc(1);
        check("a_req", 32'(imem_req), 32'd1);
        check("a_addr0", imem_addr, 32'h0);
        check("a_nvalid", 32'(if_valid), 32'd0);
        cyc(1);
        check("a_valid", 32'(if_valid), 32'd1);
        check("a_pc0", if_pc, 32'h0);
        check("a_inst0", if_inst, 32'h1);
        check("a_cnt1", 32'(count), 32'd1);
        cyc(3);
        check("a_full", 32'(count), 32'd4);
        check("a_full_req", 32'(imem_req), 32'd0);
        cyc(5);
        check("a_hold_cnt", 32'(count), 32'd4);
        check("a_hold_req", 32'(imem_req), 32'd0);
        check("a_hold_pc", if_pc, 32'h0);
        stall = 1'b0;
        cyc(1);
        check("a_pop_cnt", 32'(count), 32'd3);
        check("a_pop_noreq", 32'(imem_req), 32'd0);
        check("a_pc4", if_pc, 32'h4);
        cyc(1);
        check("a_restart", 32'(imem_req), 32'd1);
        check("a_addr10", imem_addr, 32'h10);
        check("a_pc8", if_pc, 32'h8);
        cyc(1);
        check("a_pcC", if_pc, 32'hC);
        check("a_cnt2", 32'(count), 32'd2);
        cyc(1);
        check("a_pc10", if_pc, 32'h10);
        check("a_inst10", if_inst, 32'h11);
        // Slow memory with redirect while a fetch is outstanding
        reset = 1'b1;
        lat = 3;
        cyc(1);
        reset = 1'b0;
        cyc(5);
        check("b_pc0", if_pc, 32'h0);
        check("b_addr4", imem_addr, 32'h4);
        cyc(4);
        check("b_pc4", if_pc, 32'h4);
        check("b_addr8", imem_addr, 32'h8);
        cyc(1);
        check("b_empty", 32'(if_valid), 32'd0);
        br_ctrl = 1'b1;
        br_dst = 32'h103;
        cyc(1);
        br_ctrl = 1'b0;
        check("b_drop_req", 32'(imem_req), 32'd1);
        check("b_drop_addr", imem_addr, 32'h8);
        cyc(1);
        check("b_drop_ack_addr", imem_addr, 32'h8);
        check("b_drop_nvalid", 32'(if_valid), 32'd0);
        cyc(1);
        check("b_addr100", imem_addr, 32'h100);
        check("b_ifpc100", if_pc, 32'h100);
        cyc(3);
        check("b_wait_nvalid", 32'(if_valid), 32'd0);
        cyc(1);
        check("b_valid100", 32'(if_valid), 32'd1);
        check("b_pc100", if_pc, 32'h100);
        check("b_inst100", if_inst, 32'h101);
        // Redirect coincident with ack and pop
        lat = 0;
        br_ctrl = 1'b1;
        br_dst = 32'h200;
        cyc(1);
        br_ctrl = 1'b0;
        check("c_cnt0", 32'(count), 32'd0);
        check("c_nvalid", 32'(if_valid), 32'd0);
        check("c_addr200", imem_addr, 32'h200);
        cyc(1);
        check("c_pc200", if_pc, 32'h200);
        check("c_inst200", if_inst, 32'h201);
        // Reset with three entries and a live request
        stall = 1'b1;
        cyc(2);
        check("d_cnt3", 32'(count), 32'd3);
        check("d_req", 32'(imem_req), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("d_rst_valid", 32'(if_valid), 32'd0);
        check("d_rst_cnt", 32'(count), 32'd0);
        check("d_rst_req", 32'(imem_req), 32'd0);
        cyc(1);
        reset = 1'b0;
        cyc(1);
        check("d_addr0", imem_addr, 32'h0);
        check("d_req1", 32'(imem_req), 32'd1);
        // Address wrap past 0xFFFF_FFFC
        br_ctrl = 1'b1;
        br_dst = 32'hFFFF_FFF8;
        cyc(1);
        br_ctrl = 1'b0;
        check("e_addr_f8", imem_addr, 32'hFFFF_FFF8);
        check("e_nvalid", 32'(if_valid), 32'd0);
        cyc(1);
        check("e_addr_fc", imem_addr, 32'hFFFF_FFFC);
        cyc(1);
        check("e_addr_wrap", imem_addr, 32'h0);
        cyc(1);
        check("e_cnt3", 32'(count), 32'd3);
        check("e_pc_f8", if_pc, 32'hFFFF_FFF8);
        check("e_inst_f8", if_inst, 32'hFFFF_FFF9);
        stall = 1'b0;
        cyc(1);
        check("e_pc_fc", if_pc, 32'hFFFF_FFFC);
        check("e_inst_fc", if_inst, 32'hFFFF_FFFD);
        cyc(1);
        check("e_pc_0", if_pc, 32'h0);
        check("e_inst_0", if_inst, 32'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
